// File: rtl/jt89_gg_busif.sv
// Game Gear PSG CPU write port: paces PSG data writes with READY and defers pan updates to the next cen_16.
// Acceptance on the strobe's first edge; psg_wr_n issues on the next clk_en and READY returns BUSY_CYC clk_en periods later; a PSG write while busy is dropped and flagged on ovr.
module jt89_gg_busif #(
    parameter int unsigned BUSY_CYC = 32,
    parameter logic [7:0]  PAN_RST  = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       cen_16,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       addr,
    input  logic [7:0] din,
    output logic       ready,
    output logic       psg_wr_n,
    output logic [7:0] psg_din,
    output logic [7:0] pan,
    output logic       pan_pend,
    output logic       ovr
);

    localparam logic [7:0] CNT_LOAD = 8'(BUSY_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EN,
        BUSY
    } state_t;

    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic       ready_nx, psg_wr_n_nx, ovr_nx;
    logic [7:0] psg_din_nx;
    logic [7:0] pan_next;

    logic s, s_d, acc, psg_acc, pan_acc;

    assign s       = ~cs_n & ~wr_n;
    assign acc     = s & ~s_d;
    assign psg_acc = acc & ~addr;
    assign pan_acc = acc & addr;

    // s_d resets high so a strobe held through reset release is not taken as a new write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_d <= 1'b1;
        end else begin
            s_d <= s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            ready    <= 1'b1;
            psg_wr_n <= 1'b1;
            psg_din  <= '0;
            ovr      <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            ready    <= ready_nx;
            psg_wr_n <= psg_wr_n_nx;
            psg_din  <= psg_din_nx;
            ovr      <= ovr_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        ready_nx    = ready;
        psg_wr_n_nx = 1'b1;
        psg_din_nx  = psg_din;
        ovr_nx      = 1'b0;
        case (state)
            IDLE: begin
                if (psg_acc) begin
                    psg_din_nx = din;
                    ready_nx   = 1'b0;
                    state_nx   = WAIT_EN;
                end
            end
            WAIT_EN: begin
                ovr_nx = psg_acc;
                if (clk_en) begin
                    psg_wr_n_nx = 1'b0;
                    cnt_nx      = CNT_LOAD;
                    state_nx    = BUSY;
                end
            end
            BUSY: begin
                ovr_nx = psg_acc;
                if (clk_en) begin
                    if (cnt == 8'd0) begin
                        ready_nx = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        cnt_nx = cnt - 8'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // A fresh stereo write wins over a coinciding cen_16 so the newest value is the one applied
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pan_next <= PAN_RST;
            pan      <= PAN_RST;
            pan_pend <= 1'b0;
        end else if (pan_acc) begin
            pan_next <= din;
            pan_pend <= 1'b1;
        end else if (pan_pend && cen_16) begin
            pan      <= pan_next;
            pan_pend <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jt89_gg_busif.sv
// Directed bench for jt89_gg_busif: PSG data expectations go through a scoreboard popped on each psg_wr_n pulse.
module tb_jt89_gg_busif;

    logic       clk = 1'b0;
    logic       rst, clk_en, cen_16, cs_n, wr_n, addr;
    logic [7:0] din;
    logic       ready, psg_wr_n, pan_pend, ovr;
    logic [7:0] psg_din, pan;

    jt89_gg_busif #(.BUSY_CYC(32), .PAN_RST(8'hFF)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .cen_16(cen_16),
        .cs_n(cs_n), .wr_n(wr_n), .addr(addr), .din(din),
        .ready(ready), .psg_wr_n(psg_wr_n), .psg_din(psg_din),
        .pan(pan), .pan_pend(pan_pend), .ovr(ovr)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         en_div  = 1;
    bit         cen_on  = 1'b0;
    logic [7:0] sb[$];
    int         pulses  = 0;
    int         ovrs    = 0;
    int         pan_chg = 0;
    bit         saw_0f  = 1'b0;
    logic [7:0] pan_prev = 8'hFF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (psg_wr_n === 1'b0) begin
            pulses++;
            check("sb_nonempty", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) check("psg_din_at_pulse", psg_din, sb.pop_front());
        end
        if (ovr === 1'b1) ovrs++;
        if (pan !== pan_prev) begin
            pan_chg++;
            pan_prev = pan;
        end
        if (pan === 8'h0F) saw_0f = 1'b1;
    end

    task automatic tick();
        @(negedge clk);
        #1;
        cyc++;
        clk_en = (cyc % en_div) == 0;
        cen_16 = cen_on && ((cyc % 16) == 0);
    endtask

    task automatic write(input logic a, input logic [7:0] d);
        cs_n = 1'b0; wr_n = 1'b0; addr = a; din = d;
        tick();
        cs_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic wait_ready(input int budget);
        int k = 0;
        while (ready !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        check("ready_timeout", ready, 1);
    endtask

    task automatic wait_cen(input int budget);
        int k = 0;
        while (cen_16 !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        check("cen_timeout", cen_16, 1);
    endtask

    initial begin
        int p0, o0, c0, lc, k;
        rst = 1'b0; cs_n = 1'b0; wr_n = 1'b0; addr = 1'b0; din = 8'h55;
        clk_en = 1'b1; cen_16 = 1'b0;

        // reset with strobe held, then release with strobe still held
        repeat (3) tick();
        check("rst_ready", ready, 1);
        check("rst_psg_wr_n", psg_wr_n, 1);
        check("rst_psg_din", psg_din, 0);
        check("rst_pan", pan, 8'hFF);
        check("rst_pan_pend", pan_pend, 0);
        check("rst_ovr", ovr, 0);
        rst = 1'b1;
        repeat (10) tick();
        check("held_ready", ready, 1);
        check("held_psg_din", psg_din, 0);
        check("held_pulses", pulses, 0);
        check("held_pan", pan, 8'hFF);
        cs_n = 1'b1; wr_n = 1'b1;
        tick();
        sb.push_back(8'h9F);
        write(1'b0, 8'h9F);
        wait_ready(100);
        check("first_pulses", pulses, 1);
        check("first_psg_din", psg_din, 8'h9F);

        // clk_en always on: ready low exactly BUSY_CYC+1 cycles
        p0 = pulses;
        sb.push_back(8'h80);
        write(1'b0, 8'h80);
        check("ready_fall", ready, 0);
        lc = 1;
        tick();
        check("wr_n_next_cycle", psg_wr_n, 0);
        if (ready === 1'b0) lc++;
        while (lc < 200) begin
            tick();
            if (ready === 1'b1) break;
            lc++;
        end
        check("ready_low_cycles", lc, 33);
        repeat (3) tick();
        check("busy_pulses", pulses - p0, 1);

        // clk_en every 4th cycle, second write while busy is dropped
        en_div = 4;
        p0 = pulses; o0 = ovrs;
        sb.push_back(8'hA5);
        write(1'b0, 8'hA5);
        repeat (9) tick();
        write(1'b0, 8'h3C);
        check("ovr_pulse", ovr, 1);
        tick();
        check("ovr_clear", ovr, 0);
        wait_ready(400);
        check("ovr_pulses_psg", pulses - p0, 1);
        check("ovr_count", ovrs - o0, 1);
        check("ovr_psg_din_kept", psg_din, 8'hA5);

        // two stereo writes before one cen_16: only the last is applied
        cen_on = 1'b1;
        c0 = pan_chg; saw_0f = 1'b0;
        wait_cen(40);
        tick();
        write(1'b1, 8'h0F);
        tick();
        write(1'b1, 8'h33);
        check("pan_hold_ff", pan, 8'hFF);
        check("pan_pend_set", pan_pend, 1);
        k = 0;
        while (pan_pend === 1'b1 && k < 40) begin
            tick();
            k++;
        end
        check("pan_last", pan, 8'h33);
        check("pan_pend_clr", pan_pend, 0);
        check("pan_no_0f", 32'(saw_0f), 0);
        check("pan_one_change", pan_chg - c0, 1);

        // stereo write coinciding with cen_16 waits one full cen_16 period
        wait_cen(40);
        write(1'b1, 8'hF0);
        check("pan_coinc_pend", pan_pend, 1);
        check("pan_coinc_hold", pan, 8'h33);
        lc = 0;
        while (pan_pend === 1'b1 && lc < 100) begin
            lc++;
            tick();
        end
        check("pan_pend_cycles", lc, 16);
        check("pan_f0", pan, 8'hF0);

        // reset in the middle of a busy PSG write with a stereo write pending
        p0 = pulses;
        sb.push_back(8'h11);
        write(1'b0, 8'h11);
        k = 0;
        while (pulses == p0 && k < 20) begin
            tick();
            k++;
        end
        check("mid_pulse_seen", pulses - p0, 1);
        repeat (5) tick();
        write(1'b1, 8'h5A);
        check("mid_pan_pend", pan_pend, 1);
        check("mid_ready", ready, 0);
        rst = 1'b0;
        #1;
        check("arst_ready", ready, 1);
        check("arst_psg_wr_n", psg_wr_n, 1);
        check("arst_psg_din", psg_din, 0);
        check("arst_pan", pan, 8'hFF);
        check("arst_pan_pend", pan_pend, 0);
        check("arst_ovr", ovr, 0);
        repeat (3) tick();
        rst = 1'b1;
        p0 = pulses;
        repeat (40) tick();
        check("post_rst_pulses", pulses - p0, 0);
        check("post_rst_ready", ready, 1);
        check("post_rst_pan", pan, 8'hFF);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
